// File: rtl/seven_segment_scan_mux.sv
// Round-robin common-anode 7-seg scanner with frame-atomic shadow digits and dead time.
// Optional: SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seven_segment_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1024,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     anode,
    output logic                      scan_done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW = 4 * NUM_DIGITS;
    localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] DEAD_P   = PW'(DEAD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 1 || REFRESH_DIV < 2 || DEAD_CYCLES < 0 ||
        DEAD_CYCLES >= REFRESH_DIV) begin : g_param_check
        $error("seven_segment_scan_mux: illegal parameter combination");
    end

    logic [PW-1:0]          presc_q, presc_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DW-1:0]          sh_dig_q, sh_dig_d;
    logic [NUM_DIGITS-1:0]  sh_blk_q, sh_blk_d;
    logic [DW-1:0]          pend_dig_q, pend_dig_d;
    logic [NUM_DIGITS-1:0]  pend_blk_q, pend_blk_d;
    logic                   pend_vld_q, pend_vld_d;
    logic [6:0]             seg_q, seg_d;
    logic [NUM_DIGITS-1:0]  anode_q, anode_d;
    logic                   done_q, done_d;

    logic                   frame_end;
    logic [3:0]             cur_dig;
    logic                   cur_blk;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0011000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign frame_end = (presc_q == PRE_LAST) && (idx_q == IDX_LAST);

`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    // lz[k]: digit k and everything above it is zero; digit 0 always shown
    logic [NUM_DIGITS-1:0] lz;

    always_comb begin : p_lz
        logic run;
        run = 1'b1;
        lz  = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run = run & (sh_dig_q[4*k +: 4] == 4'h0);
            if (k > 0) lz[k] = run;
        end
    end
`endif

    always_comb begin : p_sel
        cur_dig = 4'h0;
        cur_blk = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_dig = sh_dig_q[4*k +: 4];
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
                cur_blk = sh_blk_q[k] | lz[k];
`else
                cur_blk = sh_blk_q[k];
`endif
            end
        end
    end

    always_comb begin : p_next
        presc_d    = presc_q + 1'b1;
        idx_d      = idx_q;
        pend_dig_d = pend_dig_q;
        pend_blk_d = pend_blk_q;
        pend_vld_d = pend_vld_q;
        sh_dig_d   = sh_dig_q;
        sh_blk_d   = sh_blk_q;
        seg_d      = 7'h7F;
        anode_d    = '1;
        done_d     = frame_end;

        if (presc_q == PRE_LAST) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        if (load) begin
            pend_dig_d = digits_in;
            pend_blk_d = blank_in;
            pend_vld_d = 1'b1;
        end

        // Shadow only moves at the frame seam so a frame never mixes data
        if (frame_end) begin
            if (load) begin
                sh_dig_d = digits_in;
                sh_blk_d = blank_in;
            end else if (pend_vld_q) begin
                sh_dig_d = pend_dig_q;
                sh_blk_d = pend_blk_q;
            end
            pend_vld_d = 1'b0;
        end

        if (!(presc_q < DEAD_P) && !cur_blk) begin
            anode_d = ~(NUM_DIGITS'(1) << idx_q);
            seg_d   = hex7(cur_dig);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q    <= '0;
            idx_q      <= '0;
            sh_dig_q   <= '0;
            sh_blk_q   <= '1;
            pend_dig_q <= '0;
            pend_blk_q <= '1;
            pend_vld_q <= 1'b0;
            seg_q      <= 7'h7F;
            anode_q    <= '1;
            done_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            sh_dig_q   <= sh_dig_d;
            sh_blk_q   <= sh_blk_d;
            pend_dig_q <= pend_dig_d;
            pend_blk_q <= pend_blk_d;
            pend_vld_q <= pend_vld_d;
            seg_q      <= seg_d;
            anode_q    <= anode_d;
            done_q     <= done_d;
        end
    end

    assign seg       = seg_q;
    assign anode     = anode_q;
    assign scan_done = done_q;

endmodule

// File: tb/tb_seven_segment_scan_mux.sv
// Scoreboard bench for seven_segment_scan_mux (4 digits, 8-cycle slots, 2 dead cycles).
// Expected outputs are pushed per clock by a behavioural model and popped on the falling edge.
module tb_seven_segment_scan_mux;

    localparam int N     = 4;
    localparam int RD    = 8;
    localparam int DC    = 2;
    localparam int FRAME = N * RD;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] digits_in = 16'h0;
    logic [3:0]  blank_in = 4'h0;
    logic [6:0]  seg;
    logic [3:0]  anode;
    logic        scan_done;

    always #5 clk = ~clk;

    seven_segment_scan_mux #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(RD),
        .DEAD_CYCLES(DC)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .digits_in(digits_in),
        .blank_in (blank_in),
        .seg      (seg),
        .anode    (anode),
        .scan_done(scan_done)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   cur_ok;
    int   vectors = 0;
    int   miscompares = 0;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[v];
    endfunction

    // behavioural model state
    int         m_pre = 0;
    int         m_idx = 0;
    logic [3:0] m_sd [N];
    logic [3:0] m_sb = 4'hF;
    logic [15:0] m_pd = 16'h0;
    logic [3:0] m_pb = 4'hF;
    bit         m_pv = 0;

    function automatic bit m_dark(input int k);
        bit d;
        d = m_sb[k];
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
        begin
            bit z;
            z = 1;
            for (int j = k; j < N; j++) if (m_sd[j] != 4'h0) z = 0;
            if (k > 0 && z) d = 1;
        end
`endif
        return d;
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        exp_t e;
        if (!reset_n) begin
            m_pre = 0;
            m_idx = 0;
            for (int k = 0; k < N; k++) m_sd[k] = 4'h0;
            m_sb = 4'hF;
            m_pv = 0;
            exp_q.delete();
        end else begin
            e.done = (m_pre == RD - 1) && (m_idx == N - 1);
            if (m_pre < DC || m_dark(m_idx)) begin
                e.an  = 4'hF;
                e.seg = 7'h7F;
            end else begin
                e.an  = ~(4'b0001 << m_idx);
                e.seg = hex7(m_sd[m_idx]);
            end
            exp_q.push_back(e);
            if (e.done) begin
                if (load) begin
                    for (int k = 0; k < N; k++) m_sd[k] = digits_in[4*k +: 4];
                    m_sb = blank_in;
                end else if (m_pv) begin
                    for (int k = 0; k < N; k++) m_sd[k] = m_pd[4*k +: 4];
                    m_sb = m_pb;
                end
            end
            if (load) begin
                m_pd = digits_in;
                m_pb = blank_in;
                m_pv = 1;
            end
            if (e.done) m_pv = 0;
            if (m_pre == RD - 1) begin
                m_pre = 0;
                m_idx = (m_idx == N - 1) ? 0 : m_idx + 1;
            end else begin
                m_pre = m_pre + 1;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        cur_ok = exp_q.size() > 0;
        if (cur_ok) cur = exp_q.pop_front();
    endtask

    task automatic test_reset();
        int pulses = 0;
        reset_n = 1'b0;
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (seg !== 7'h7F || anode !== 4'hF || scan_done !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold seg=%b anode=%b done=%b want 1111111 1111 0", seg, anode, scan_done);
            end
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            vectors++;
            if (!cur_ok || seg !== cur.seg || anode !== cur.an || scan_done !== cur.done) begin
                miscompares++;
                $display("FAIL reset_model t=%0t seg=%b/%b anode=%b/%b done=%b/%b", $time, seg, cur.seg, anode, cur.an, scan_done, cur.done);
            end
            vectors++;
            if (anode !== 4'hF || seg !== 7'h7F || scan_done !== (((i + 1) % FRAME) == 0)) begin
                miscompares++;
                $display("FAIL reset_dark i=%0d seg=%b anode=%b done=%b", i, seg, anode, scan_done);
            end
            if (scan_done === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 3) begin
            miscompares++;
            $display("FAIL reset_pulses got %0d want 3", pulses);
        end
    endtask

    task automatic test_load();
        int good0 = 0, good3 = 0, bad = 0;
        load = 1'b1;
        digits_in = 16'h1234;
        blank_in = 4'h0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            if (i == 0) load = 1'b0;
            vectors++;
            if (!cur_ok || seg !== cur.seg || anode !== cur.an || scan_done !== cur.done) begin
                miscompares++;
                $display("FAIL load_model t=%0t seg=%b/%b anode=%b/%b done=%b/%b", $time, seg, cur.seg, anode, cur.an, scan_done, cur.done);
            end
            if (i >= 2 * FRAME) begin
                if (anode === 4'b1110) begin
                    if (seg === 7'b0011001) good0++; else bad++;
                end
                if (anode === 4'b0111) begin
                    if (seg === 7'b1111001) good3++; else bad++;
                end
            end
        end
        vectors++;
        if (good0 != 6 || good3 != 6 || bad != 0) begin
            miscompares++;
            $display("FAIL load_slots d0=%0d d3=%0d bad=%0d want 6 6 0", good0, good3, bad);
        end
    endtask

    task automatic test_atomic();
        int good = 0, bad = 0, found = 0, g6 = 0, b6 = 0;
        load = 1'b1;
        digits_in = 16'hAAAA;
        blank_in = 4'h0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            if (i == 0) load = 1'b0;
            if (i == 10) begin
                load = 1'b1;
                digits_in = 16'h5555;
            end
            if (i == 11) load = 1'b0;
            vectors++;
            if (!cur_ok || seg !== cur.seg || anode !== cur.an || scan_done !== cur.done) begin
                miscompares++;
                $display("FAIL atomic_model t=%0t seg=%b/%b anode=%b/%b done=%b/%b", $time, seg, cur.seg, anode, cur.an, scan_done, cur.done);
            end
            vectors++;
            if (seg === 7'b0001000) begin
                miscompares++;
                $display("FAIL atomic_noA t=%0t seg=%b must not be %b", $time, seg, 7'b0001000);
            end
            if (i >= 2 * FRAME && anode !== 4'hF) begin
                if (seg === 7'b0010010) good++; else bad++;
            end
        end
        vectors++;
        if (good != 24 || bad != 0) begin
            miscompares++;
            $display("FAIL atomic_five lit5=%0d other=%0d want 24 0", good, bad);
        end
        for (int i = 0; i < 2 * FRAME && found == 0; i++) begin
            if (m_pre == RD - 1 && m_idx == N - 1) begin
                found = 1;
            end else begin
                tick();
                vectors++;
                if (!cur_ok || seg !== cur.seg || anode !== cur.an || scan_done !== cur.done) begin
                    miscompares++;
                    $display("FAIL atomic_wait t=%0t seg=%b/%b anode=%b/%b", $time, seg, cur.seg, anode, cur.an);
                end
            end
        end
        vectors++;
        if (found == 0) begin
            miscompares++;
            $display("FAIL atomic_boundary_search got none want boundary");
        end
        load = 1'b1;
        digits_in = 16'h9876;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (i == 0) load = 1'b0;
            vectors++;
            if (!cur_ok || seg !== cur.seg || anode !== cur.an || scan_done !== cur.done) begin
                miscompares++;
                $display("FAIL bypass_model t=%0t seg=%b/%b anode=%b/%b done=%b/%b", $time, seg, cur.seg, anode, cur.an, scan_done, cur.done);
            end
            if (anode === 4'b1110) begin
                if (seg === hex7(4'h6)) g6++; else b6++;
            end
        end
        vectors++;
        if (g6 != 6 || b6 != 0) begin
            miscompares++;
            $display("FAIL bypass_slot0 lit6=%0d other=%0d want 6 0", g6, b6);
        end
    endtask

    task automatic test_blank();
        int g1 = 0, g3 = 0, bad = 0;
        load = 1'b1;
        digits_in = 16'h8888;
        blank_in = 4'b0101;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            if (i == 0) load = 1'b0;
            vectors++;
            if (!cur_ok || seg !== cur.seg || anode !== cur.an || scan_done !== cur.done) begin
                miscompares++;
                $display("FAIL blank_model t=%0t seg=%b/%b anode=%b/%b done=%b/%b", $time, seg, cur.seg, anode, cur.an, scan_done, cur.done);
            end
            if (i >= 2 * FRAME) begin
                if (anode === 4'b1101 && seg === 7'b0000000) g1++;
                else if (anode === 4'b0111 && seg === 7'b0000000) g3++;
                else if (anode !== 4'hF || seg !== 7'h7F) bad++;
            end
        end
        vectors++;
        if (g1 != 6 || g3 != 6 || bad != 0) begin
            miscompares++;
            $display("FAIL blank_slots d1=%0d d3=%0d other=%0d want 6 6 0", g1, g3, bad);
        end
        blank_in = 4'h0;
    endtask

    task automatic test_reset_mid();
        int found = 0;
        load = 1'b1;
        digits_in = 16'h4321;
        blank_in = 4'h0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (i == 0) load = 1'b0;
            vectors++;
            if (!cur_ok || seg !== cur.seg || anode !== cur.an || scan_done !== cur.done) begin
                miscompares++;
                $display("FAIL mid_model t=%0t seg=%b/%b anode=%b/%b", $time, seg, cur.seg, anode, cur.an);
            end
        end
        for (int i = 0; i < 2 * FRAME && found == 0; i++) begin
            if (m_idx == 2 && m_pre == 4) found = 1;
            else tick();
        end
        vectors++;
        if (found == 0 || anode !== 4'b1011 || seg !== 7'b0110000) begin
            miscompares++;
            $display("FAIL mid_lit found=%0d anode=%b seg=%b want 1011 0110000", found, anode, seg);
        end
        load = 1'b1;
        digits_in = 16'hFFFF;
        tick();
        load = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if (seg !== 7'h7F || anode !== 4'hF || scan_done !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_async seg=%b anode=%b done=%b want 1111111 1111 0", seg, anode, scan_done);
        end
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            vectors++;
            if (!cur_ok || seg !== cur.seg || anode !== cur.an || scan_done !== cur.done) begin
                miscompares++;
                $display("FAIL mid_after_model t=%0t seg=%b/%b anode=%b/%b", $time, seg, cur.seg, anode, cur.an);
            end
            vectors++;
            if (anode !== 4'hF || seg !== 7'h7F || scan_done !== (((i + 1) % FRAME) == 0)) begin
                miscompares++;
                $display("FAIL mid_after_dark i=%0d seg=%b anode=%b done=%b", i, seg, anode, scan_done);
            end
        end
    endtask

    task automatic test_zero();
        logic [15:0] pats [2];
        pats[0] = 16'h0050;
        pats[1] = 16'h0000;
        for (int p = 0; p < 2; p++) begin
            int lit [N];
            int want [N];
            int bad = 0;
            for (int k = 0; k < N; k++) begin
                bit sup;
                sup = 0;
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
                sup = (k > 0) && ((pats[p] >> (4 * k)) == 16'h0);
`endif
                lit[k]  = 0;
                want[k] = sup ? 0 : 6;
            end
            load = 1'b1;
            digits_in = pats[p];
            blank_in = 4'h0;
            for (int i = 0; i < 3 * FRAME; i++) begin
                tick();
                if (i == 0) load = 1'b0;
                vectors++;
                if (!cur_ok || seg !== cur.seg || anode !== cur.an || scan_done !== cur.done) begin
                    miscompares++;
                    $display("FAIL zero_model t=%0t seg=%b/%b anode=%b/%b", $time, seg, cur.seg, anode, cur.an);
                end
                if (i >= 2 * FRAME && anode !== 4'hF) begin
                    for (int k = 0; k < N; k++) begin
                        if (anode === ~(4'b0001 << k)) begin
                            if (seg === hex7(pats[p][4*k +: 4])) lit[k]++; else bad++;
                        end
                    end
                end
            end
            for (int k = 0; k < N; k++) begin
                vectors++;
                if (lit[k] != want[k]) begin
                    miscompares++;
                    $display("FAIL zero_digit pat=%h k=%0d lit=%0d want %0d", pats[p], k, lit[k], want[k]);
                end
            end
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL zero_seg pat=%h wrong=%0d want 0", pats[p], bad);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) m_sd[k] = 4'h0;
        test_reset();
        test_load();
        test_atomic();
        test_blank();
        test_reset_mid();
        test_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
